// File: rtl/cmd_rx_frame.sv
// cmd_rx_frame: assembles 6-byte command frames (HEAD, dev, mod, addr, data, chk)
// from a byte stream, checks the 8-bit additive checksum, and presents the
// decoded fields with a one-cycle cmdr_vld pulse. Aborts partial frames on an
// inter-byte timeout counted in 1 us ticks and keeps saturating error counts.
//
// Handshake: byte_in is valid only in cycles where byte_vld is high. There is
// no ready/backpressure. Every strobed byte is consumed in that cycle.
// cmdr_vld is a one-cycle pulse with no ready. The downstream stage must take
// cmdr_* in the pulse cycle. The fields then hold until the next good frame.
module cmd_rx_frame #(
  parameter logic [7:0]  HEAD       = 8'hA5,
  parameter int unsigned TIMEOUT_US = 1000
) (
  input  logic       clk_sys,
  input  logic       rst_n,
  input  logic       pluse_us,
  input  logic [7:0] byte_in,
  input  logic       byte_vld,
  output logic [7:0] cmdr_dev,
  output logic [7:0] cmdr_mod,
  output logic [7:0] cmdr_addr,
  output logic [7:0] cmdr_data,
  output logic       cmdr_vld,
  output logic       frame_busy,
  output logic [7:0] err_cnt,
  output logic [7:0] to_cnt,
  output logic [2:0] dbg_state
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_DEV  = 3'd1;
  localparam logic [2:0] S_MOD  = 3'd2;
  localparam logic [2:0] S_ADDR = 3'd3;
  localparam logic [2:0] S_DATA = 3'd4;
  localparam logic [2:0] S_CHK  = 3'd5;

  // The abort fires on the tick that would bring the count to TIMEOUT_US.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_US - 1);

  logic [2:0]  state_q, state_d;
  logic [7:0]  sum_q, sum_d;
  logic [7:0]  sh_dev_q, sh_dev_d;
  logic [7:0]  sh_mod_q, sh_mod_d;
  logic [7:0]  sh_addr_q, sh_addr_d;
  logic [7:0]  sh_data_q, sh_data_d;
  logic [7:0]  dev_q, dev_d;
  logic [7:0]  mod_q, mod_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic        vld_q, vld_d;
  logic [15:0] tmo_q, tmo_d;
  logic [7:0]  err_q, err_d;
  logic [7:0]  to_q, to_d;

  // Next-state logic: frame FSM, field capture, timeout and error counters.
  always_comb begin
    state_d   = state_q;
    sum_d     = sum_q;
    sh_dev_d  = sh_dev_q;
    sh_mod_d  = sh_mod_q;
    sh_addr_d = sh_addr_q;
    sh_data_d = sh_data_q;
    dev_d     = dev_q;
    mod_d     = mod_q;
    addr_d    = addr_q;
    data_d    = data_q;
    vld_d     = 1'b0;
    tmo_d     = tmo_q;
    err_d     = err_q;
    to_d      = to_q;

    if (byte_vld) begin
      // A byte always restarts the inter-byte timer. This also covers a byte
      // that arrives on the terminal tick.
      tmo_d = 16'd0;
      case (state_q)
        S_IDLE: begin
          if (byte_in == HEAD) state_d = S_DEV;
        end
        S_DEV: begin
          sh_dev_d = byte_in;
          sum_d    = byte_in;
          state_d  = S_MOD;
        end
        S_MOD: begin
          sh_mod_d = byte_in;
          sum_d    = sum_q + byte_in;
          state_d  = S_ADDR;
        end
        S_ADDR: begin
          sh_addr_d = byte_in;
          sum_d     = sum_q + byte_in;
          state_d   = S_DATA;
        end
        S_DATA: begin
          sh_data_d = byte_in;
          sum_d     = sum_q + byte_in;
          state_d   = S_CHK;
        end
        S_CHK: begin
          state_d = S_IDLE;
          if (byte_in == sum_q) begin
            dev_d  = sh_dev_q;
            mod_d  = sh_mod_q;
            addr_d = sh_addr_q;
            data_d = sh_data_q;
            vld_d  = 1'b1;
          end else if (err_q != 8'hFF) begin
            err_d = err_q + 8'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q == S_IDLE) begin
      tmo_d = 16'd0;
    end else if (pluse_us) begin
      if (tmo_q == TMO_LAST) begin
        state_d = S_IDLE;
        tmo_d   = 16'd0;
        if (to_q != 8'hFF) to_d = to_q + 8'd1;
      end else begin
        tmo_d = tmo_q + 16'd1;
      end
    end
  end

  // State and datapath registers, asynchronously cleared.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      sum_q     <= 8'd0;
      sh_dev_q  <= 8'd0;
      sh_mod_q  <= 8'd0;
      sh_addr_q <= 8'd0;
      sh_data_q <= 8'd0;
      dev_q     <= 8'd0;
      mod_q     <= 8'd0;
      addr_q    <= 8'd0;
      data_q    <= 8'd0;
      vld_q     <= 1'b0;
      tmo_q     <= 16'd0;
      err_q     <= 8'd0;
      to_q      <= 8'd0;
    end else begin
      state_q   <= state_d;
      sum_q     <= sum_d;
      sh_dev_q  <= sh_dev_d;
      sh_mod_q  <= sh_mod_d;
      sh_addr_q <= sh_addr_d;
      sh_data_q <= sh_data_d;
      dev_q     <= dev_d;
      mod_q     <= mod_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      vld_q     <= vld_d;
      tmo_q     <= tmo_d;
      err_q     <= err_d;
      to_q      <= to_d;
    end
  end

  assign cmdr_dev   = dev_q;
  assign cmdr_mod   = mod_q;
  assign cmdr_addr  = addr_q;
  assign cmdr_data  = data_q;
  assign cmdr_vld   = vld_q;
  assign frame_busy = (state_q != S_IDLE);
  assign err_cnt    = err_q;
  assign to_cnt     = to_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_cmd_rx_frame.sv
// Directed bench for cmd_rx_frame: good/bad frames, junk and in-frame header,
// timeout abort, byte on terminal tick, zero-gap frames, saturation and reset.
module tb_cmd_rx_frame;

  logic       clk_sys;
  logic       rst_n;
  logic       pluse_us;
  logic [7:0] byte_in;
  logic       byte_vld;
  logic [7:0] cmdr_dev, cmdr_mod, cmdr_addr, cmdr_data;
  logic       cmdr_vld;
  logic       frame_busy;
  logic [7:0] err_cnt, to_cnt;
  logic [2:0] dbg_state;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  cmd_rx_frame #(.HEAD(8'hA5), .TIMEOUT_US(1000)) dut (
    .clk_sys    (clk_sys),
    .rst_n      (rst_n),
    .pluse_us   (pluse_us),
    .byte_in    (byte_in),
    .byte_vld   (byte_vld),
    .cmdr_dev   (cmdr_dev),
    .cmdr_mod   (cmdr_mod),
    .cmdr_addr  (cmdr_addr),
    .cmdr_data  (cmdr_data),
    .cmdr_vld   (cmdr_vld),
    .frame_busy (frame_busy),
    .err_cnt    (err_cnt),
    .to_cnt     (to_cnt),
    .dbg_state  (dbg_state)
  );

  // Clock and reset
  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // Driver tasks: inputs change on the falling edge.
  task automatic drive_byte(input logic [7:0] b);
    @(negedge clk_sys);
    byte_in  = b;
    byte_vld = 1'b1;
  endtask

  task automatic release_bus();
    @(negedge clk_sys);
    byte_vld = 1'b0;
    pluse_us = 1'b0;
  endtask

  task automatic drive_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_sys);
      byte_vld = 1'b0;
      pluse_us = 1'b1;
    end
    @(negedge clk_sys);
    pluse_us = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pluse_us = 1'b0; byte_in = 8'h00; byte_vld = 1'b0;
    repeat (3) @(negedge clk_sys);
    chk_cnt++;
    if ({cmdr_dev, cmdr_mod, cmdr_addr, cmdr_data, cmdr_vld, frame_busy, err_cnt, to_cnt} !== 50'd0)
      $display("FAIL reset_outputs: got dev=%h mod=%h addr=%h data=%h vld=%b busy=%b err=%h to=%h, want all 0",
               cmdr_dev, cmdr_mod, cmdr_addr, cmdr_data, cmdr_vld, frame_busy, err_cnt, to_cnt);
    else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk_sys);
  endtask

  task automatic test_good_frame();
    drive_byte(8'hA5); drive_byte(8'hFF); drive_byte(8'h00);
    drive_byte(8'h00); drive_byte(8'h03);
    chk_cnt++;
    if (frame_busy !== 1'b1) $display("FAIL good_busy: got %b want 1", frame_busy);
    else pass_cnt++;
    drive_byte(8'h02);
    chk_cnt++;
    if (cmdr_vld !== 1'b0) $display("FAIL good_vld_early: got %b want 0", cmdr_vld);
    else pass_cnt++;
    release_bus();
    chk_cnt++;
    if ({cmdr_vld, cmdr_dev, cmdr_mod, cmdr_addr, cmdr_data} !== {1'b1, 32'hFF000003})
      $display("FAIL good_fields: got vld=%b %h %h %h %h want 1 ff 00 00 03",
               cmdr_vld, cmdr_dev, cmdr_mod, cmdr_addr, cmdr_data);
    else pass_cnt++;
    chk_cnt++;
    if (err_cnt !== 8'h00) $display("FAIL good_err: got %h want 00", err_cnt);
    else pass_cnt++;
    @(negedge clk_sys);
    chk_cnt++;
    if (cmdr_vld !== 1'b0 || frame_busy !== 1'b0)
      $display("FAIL good_pulse_width: got vld=%b busy=%b want 0 0", cmdr_vld, frame_busy);
    else pass_cnt++;
  endtask

  task automatic test_bad_checksum();
    logic [7:0] f [6];
    f = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00};
    for (int i = 0; i < 6; i++) drive_byte(f[i]);
    release_bus();
    chk_cnt++;
    if (cmdr_vld !== 1'b0 || {cmdr_dev, cmdr_mod, cmdr_addr, cmdr_data} !== 32'hFF000003)
      $display("FAIL bad_hold: got vld=%b fields=%h want 0 ff000003",
               cmdr_vld, {cmdr_dev, cmdr_mod, cmdr_addr, cmdr_data});
    else pass_cnt++;
    chk_cnt++;
    if (err_cnt !== 8'h01) $display("FAIL bad_err: got %h want 01", err_cnt);
    else pass_cnt++;
    f[5] = 8'h0A;
    for (int i = 0; i < 6; i++) drive_byte(f[i]);
    release_bus();
    chk_cnt++;
    if (cmdr_vld !== 1'b1 || {cmdr_dev, cmdr_mod, cmdr_addr, cmdr_data} !== 32'h01020304)
      $display("FAIL bad_resend: got vld=%b fields=%h want 1 01020304",
               cmdr_vld, {cmdr_dev, cmdr_mod, cmdr_addr, cmdr_data});
    else pass_cnt++;
  endtask

  task automatic test_junk_header();
    logic [7:0] f [8];
    f = '{8'h00, 8'h11, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hE4};
    for (int i = 0; i < 8; i++) drive_byte(f[i]);
    release_bus();
    chk_cnt++;
    if (cmdr_vld !== 1'b0 || err_cnt !== 8'h02 || frame_busy !== 1'b0)
      $display("FAIL junk_badchk: got vld=%b err=%h busy=%b want 0 02 0", cmdr_vld, err_cnt, frame_busy);
    else pass_cnt++;
    for (int i = 0; i < 5; i++) drive_byte(8'hA5);
    drive_byte(8'h94);
    release_bus();
    chk_cnt++;
    if (cmdr_vld !== 1'b1 || {cmdr_dev, cmdr_mod, cmdr_addr, cmdr_data} !== 32'hA5A5A5A5)
      $display("FAIL junk_resend: got vld=%b fields=%h want 1 a5a5a5a5",
               cmdr_vld, {cmdr_dev, cmdr_mod, cmdr_addr, cmdr_data});
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    int vld_seen;
    drive_byte(8'hA5); drive_byte(8'h01);
    release_bus();
    drive_ticks(999);
    chk_cnt++;
    if (frame_busy !== 1'b1 || to_cnt !== 8'h00)
      $display("FAIL tmo_999: got busy=%b to=%h want 1 00", frame_busy, to_cnt);
    else pass_cnt++;
    drive_ticks(1);
    chk_cnt++;
    if (frame_busy !== 1'b0 || to_cnt !== 8'h01)
      $display("FAIL tmo_abort: got busy=%b to=%h want 0 01", frame_busy, to_cnt);
    else pass_cnt++;
    vld_seen = 0;
    for (int i = 2; i <= 6; i++) begin
      drive_byte(8'(i));
      if (cmdr_vld) vld_seen++;
    end
    release_bus();
    if (cmdr_vld) vld_seen++;
    chk_cnt++;
    if (vld_seen != 0 || err_cnt !== 8'h02)
      $display("FAIL tmo_tail: got vld_pulses=%0d err=%h want 0 02", vld_seen, err_cnt);
    else pass_cnt++;
  endtask

  task automatic test_byte_on_tick();
    drive_byte(8'hA5); drive_byte(8'h01); drive_byte(8'h02);
    release_bus();
    drive_ticks(999);
    // Terminal tick and byte in the same cycle: the byte must win.
    @(negedge clk_sys);
    byte_in = 8'h03; byte_vld = 1'b1; pluse_us = 1'b1;
    @(negedge clk_sys);
    byte_vld = 1'b0; pluse_us = 1'b0;
    chk_cnt++;
    if (frame_busy !== 1'b1 || to_cnt !== 8'h01)
      $display("FAIL tick_race: got busy=%b to=%h want 1 01", frame_busy, to_cnt);
    else pass_cnt++;
    drive_byte(8'h04); drive_byte(8'h0A);
    release_bus();
    chk_cnt++;
    if (cmdr_vld !== 1'b1 || {cmdr_dev, cmdr_mod, cmdr_addr, cmdr_data} !== 32'h01020304)
      $display("FAIL tick_frame: got vld=%b fields=%h want 1 01020304",
               cmdr_vld, {cmdr_dev, cmdr_mod, cmdr_addr, cmdr_data});
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] f [12];
    f = '{8'hA5, 8'h10, 8'h20, 8'h30, 8'h40, 8'hA0,
          8'hA5, 8'hF0, 8'hF1, 8'hF2, 8'hF3, 8'hC6};
    for (int i = 0; i < 12; i++) begin
      drive_byte(f[i]);
      if (i == 6) begin
        chk_cnt++;
        if (cmdr_vld !== 1'b1 || {cmdr_dev, cmdr_mod, cmdr_addr, cmdr_data} !== 32'h10203040)
          $display("FAIL b2b_first: got vld=%b fields=%h want 1 10203040",
                   cmdr_vld, {cmdr_dev, cmdr_mod, cmdr_addr, cmdr_data});
        else pass_cnt++;
      end
    end
    release_bus();
    chk_cnt++;
    if (cmdr_vld !== 1'b1 || {cmdr_dev, cmdr_mod, cmdr_addr, cmdr_data} !== 32'hF0F1F2F3)
      $display("FAIL b2b_second: got vld=%b fields=%h want 1 f0f1f2f3",
               cmdr_vld, {cmdr_dev, cmdr_mod, cmdr_addr, cmdr_data});
    else pass_cnt++;
  endtask

  task automatic test_saturation();
    logic [7:0] f [6];
    f = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
    for (int n = 0; n < 300; n++)
      for (int i = 0; i < 6; i++) drive_byte(f[i]);
    release_bus();
    chk_cnt++;
    if (err_cnt !== 8'hFF || {cmdr_dev, cmdr_mod, cmdr_addr, cmdr_data} !== 32'hF0F1F2F3)
      $display("FAIL sat_err: got err=%h fields=%h want ff f0f1f2f3",
               err_cnt, {cmdr_dev, cmdr_mod, cmdr_addr, cmdr_data});
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_frame();
    drive_byte(8'hA5); drive_byte(8'h01); drive_byte(8'h02);
    release_bus();
    #1 rst_n = 1'b0;
    #1;
    chk_cnt++;
    if ({cmdr_dev, cmdr_mod, cmdr_addr, cmdr_data, cmdr_vld, frame_busy, err_cnt, to_cnt} !== 50'd0)
      $display("FAIL rst_mid: got fields=%h vld=%b busy=%b err=%h to=%h want all 0",
               {cmdr_dev, cmdr_mod, cmdr_addr, cmdr_data}, cmdr_vld, frame_busy, err_cnt, to_cnt);
    else pass_cnt++;
    @(negedge clk_sys);
    rst_n = 1'b1;
    drive_byte(8'hA5); drive_byte(8'h11); drive_byte(8'h22);
    drive_byte(8'h33); drive_byte(8'h44); drive_byte(8'hAA);
    release_bus();
    chk_cnt++;
    if (cmdr_vld !== 1'b1 || {cmdr_dev, cmdr_mod, cmdr_addr, cmdr_data} !== 32'h11223344 || err_cnt !== 8'h00)
      $display("FAIL rst_after: got vld=%b fields=%h err=%h want 1 11223344 00",
               cmdr_vld, {cmdr_dev, cmdr_mod, cmdr_addr, cmdr_data}, err_cnt);
    else pass_cnt++;
  endtask

  // Test sequence and final report
  initial begin
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_junk_header();
    test_timeout();
    test_byte_on_tick();
    test_back_to_back();
    test_saturation();
    test_reset_mid_frame();
    repeat (2) @(negedge clk_sys);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/cmd_rx_frame.md
Name: cmd_rx_frame

Overview:
Upstream stage of the command path. Receives a byte stream (one byte per byte_vld strobe from the serial receiver) and assembles fixed-length command frames. It verifies each frame's checksum and presents the decoded dev/mod/addr/data fields with a one-cycle cmdr_vld pulse. These outputs directly feed the cmdr_* inputs of the factory control stage. The block also detects inter-byte timeouts using the 1 us tick and keeps saturating error counters.

Parameters:
HEAD, 8'hA5, frame header byte
TIMEOUT_US, 1000, inter-byte timeout in microseconds; legal range 1..65535

Ports:
clk_sys  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
pluse_us  input  1  one-cycle tick every 1 us
byte_in  input  8  received byte, qualified by byte_vld
byte_vld  input  1  one-cycle strobe, byte_in valid
cmdr_dev  output  8  device id of last good frame
cmdr_mod  output  8  module id of last good frame
cmdr_addr  output  8  register address of last good frame
cmdr_data  output  8  data of last good frame
cmdr_vld  output  1  one-cycle pulse, new good frame on cmdr_*
frame_busy  output  1  high while a frame is partially received (state != IDLE)
err_cnt  output  8  checksum-failure count, saturating
to_cnt  output  8  timeout-abort count, saturating

Behaviour:
- Reset: async on rst_n low. State goes to IDLE. All outputs, shadow field registers and the timeout counter go to 0.
- Frame format, 6 bytes: HEAD, dev, mod, addr, data, chk.
- chk = (dev + mod + addr + data) mod 256, using 8-bit wrap-around addition.
- FSM states: IDLE, DEV, MOD, ADDR, DATA, CHK. Transitions occur only on byte_vld.
  - IDLE: if byte_in == HEAD, go to DEV. Any other byte is discarded and the state stays IDLE.
  - DEV, MOD, ADDR, DATA: capture byte_in into the shadow register for that field, accumulate the running sum, and advance to the next state.
  - A byte equal to HEAD inside a frame is treated as ordinary data. There is no resync.
  - CHK, byte_in == sum: copy the shadow registers to cmdr_* and pulse cmdr_vld for exactly one cycle, then go to IDLE.
  - CHK, byte_in != sum: go to IDLE, leave cmdr_* unchanged, and increment err_cnt.
- Latency: cmdr_vld and the updated cmdr_* fields are both registered. They appear in the cycle after the clock edge that samples the chk byte, as a single-cycle pulse.
- Field hold: cmdr_* hold their value until the next good frame. They never change on a bad or aborted frame.
- Timeout:
  - A 16-bit counter is cleared on every byte_vld and while in IDLE.
  - Outside IDLE it increments on pluse_us.
  - When the counter reaches TIMEOUT_US, the FSM goes to IDLE, the counter clears and to_cnt increments.
  - If byte_vld and the terminal pluse_us fall in the same cycle, the byte wins: it is processed normally and the counter clears.
- Counters: err_cnt and to_cnt increment by 1 per event and saturate at 8'hFF. They never wrap and are cleared only by reset.
- Back-to-back input: byte_vld may be asserted on consecutive cycles.
  - A new HEAD in the same cycle that cmdr_vld is high is accepted.
  - Zero-gap frames are fully supported.
- frame_busy is combinationally equal to (state != IDLE).

Test Plan:
- Good frame: A5 FF 00 00 03 02 (sum 0x102 -> chk 0x02) -> one-cycle cmdr_vld in the cycle after chk. cmdr_dev=FF, mod=00, addr=00, data=03. err_cnt=0.
- Bad checksum: A5 01 02 03 04 00 (correct chk 0x0A) -> no cmdr_vld, cmdr_* unchanged, err_cnt=1. A following A5 01 02 03 04 0A gives cmdr_vld with data=04.
- Junk and in-frame header: 00 11 A5 A5 A5 A5 A5 E4 (4*A5=0x294 -> chk 0x94) -> junk bytes ignored. The E4 byte fails the checksum, so err_cnt increments. Resend with chk 94 -> cmdr_vld with all fields = A5.
- Timeout: A5 01, then TIMEOUT_US=1000 pluse_us ticks with no byte -> frame_busy drops, to_cnt=1. Then 02 03 04 05 06 produce no cmdr_vld.
- Byte on terminal tick: byte_vld coincident with the 1000th tick -> no abort, to_cnt unchanged, frame completes normally.
- Saturation and reset: 300 bad frames -> err_cnt=FF. rst_n pulsed low mid-frame (after A5 01 02) -> immediately all outputs 0 and frame_busy=0. A good frame after reset is decoded correctly.
